// File: rtl/pheap_level_stage_if.sv
// Step handshake between the sequencer and one heap level: start/op/pos/in_kv in, result out.
// The sequencer side uses master; the level stage uses slave.
interface pheap_level_stage_if #(
  parameter int LEVEL = 2,
  parameter int KW    = 16,
  parameter int VW    = 16
);
  localparam int PW = (LEVEL > 1) ? LEVEL - 1 : 1;

  logic                 start;
  logic [1:0]           op;
  logic [PW-1:0]        pos;
  logic [KW+VW-1:0]     in_kv;
  logic [1:0]           done;
  logic [KW+VW-1:0]     out_kv;
  logic [LEVEL-1:0]     end_pos;

  modport master (output start, op, pos, in_kv, input done, out_kv, end_pos);
  modport slave  (input start, op, pos, in_kv, output done, out_kv, end_pos);
endinterface

// File: rtl/pheap_level_stage.sv
// One level of a pipelined min-heap: a step starts in cycle t, resolves in t+1 and commits at the t+1 edge.
// Results are combinational in t+1 and held in registers while idle; issue interval is two cycles.
module pheap_level_stage #(
  parameter int LEVEL  = 2,
  parameter int LEVELS = 4,
  parameter int KW     = 16,
  parameter int VW     = 16,
  localparam int CW    = LEVELS,
  localparam int EW    = 1 + KW + VW + CW,
  localparam int PW    = (LEVEL > 1) ? LEVEL - 1 : 1,
  localparam int PPW   = (LEVEL > 2) ? LEVEL - 2 : 1,
  localparam int KVW   = KW + VW
) (
  input  logic                 clk,
  input  logic                 rst,
  pheap_level_stage_if.slave   up,
  output logic [PW-1:0]        child_addr,
  input  logic [EW-1:0]        child_l,
  input  logic [EW-1:0]        child_r,
  input  logic [PPW-1:0]       par_addr,
  output logic [EW-1:0]        par_l,
  output logic [EW-1:0]        par_r,
  output logic [KVW-1:0]       head_kv,
  output logic                 full,
  output logic                 empty
);
  localparam int NN = 2 ** (LEVEL - 1);
  localparam logic [CW-1:0] CAP_RST = CW'((1 << (LEVELS - LEVEL + 1)) - 1);

  localparam logic [1:0] OP_ENQ     = 2'd1;
  localparam logic [1:0] OP_DEQ     = 2'd2;
  localparam logic [1:0] OP_ENQ_DEQ = 2'd3;
  localparam logic [1:0] R_DONE     = 2'd0;
  localparam logic [1:0] R_BUSY     = 2'd1;
  localparam logic [1:0] R_NEXT     = 2'd2;

  typedef struct packed {
    logic          valid;
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    logic [CW-1:0] cap;
  } entry_t;

  entry_t         node_q [NN];
  entry_t         node_d [NN];
  logic           busy_q, busy_d;
  logic [1:0]     op_q, op_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [KVW-1:0] kv_q, kv_d;
  logic [KVW-1:0] out_kv_q, out_kv_d;
  logic [LEVEL-1:0] end_pos_q, end_pos_d;

  logic [PW-1:0]  t_idx, pl_idx, pr_idx;
  entry_t         t_e, l_e, r_e, c_e, n_e;
  logic [KW-1:0]  in_key;
  logic           sel_r, any_c, dir, wr;
  logic [1:0]     res;

  always_comb begin
    t_idx  = (NN == 1) ? '0 : pos_q;
    t_e    = node_q[t_idx];
    l_e    = child_l;
    r_e    = child_r;
    in_key = kv_q[KVW-1:VW];
    // Minimum valid child, left wins ties.
    sel_r  = r_e.valid && (!l_e.valid || (r_e.key < l_e.key));
    any_c  = l_e.valid || r_e.valid;
    c_e    = sel_r ? r_e : l_e;

    n_e       = t_e;
    wr        = 1'b0;
    res       = R_DONE;
    dir       = 1'b0;
    out_kv_d  = out_kv_q;
    end_pos_d = end_pos_q;

    if (busy_q) begin
      case (op_q)
        OP_ENQ: begin
          wr      = 1'b1;
          n_e.cap = t_e.cap - 1'b1;
          if (!t_e.valid) begin
            n_e.valid = 1'b1;
            n_e.key   = in_key;
            n_e.value = kv_q[VW-1:0];
          end else begin
            if (in_key < t_e.key) begin
              n_e.key   = in_key;
              n_e.value = kv_q[VW-1:0];
              out_kv_d  = {t_e.key, t_e.value};
            end else begin
              out_kv_d  = kv_q;
            end
            // Descend toward the subtree with more free slots, left on tie.
            dir = (r_e.cap > l_e.cap);
            res = R_NEXT;
          end
        end
        OP_DEQ: begin
          wr      = 1'b1;
          n_e.cap = t_e.cap + 1'b1;
          if (!any_c) begin
            n_e.valid = 1'b0;
          end else begin
            n_e.valid = 1'b1;
            n_e.key   = c_e.key;
            n_e.value = c_e.value;
            out_kv_d  = {c_e.key, c_e.value};
            dir       = sel_r;
            res       = R_NEXT;
          end
        end
        OP_ENQ_DEQ: begin
          wr = 1'b1;
          if (!any_c || (in_key <= c_e.key)) begin
            n_e.valid = 1'b1;
            n_e.key   = in_key;
            n_e.value = kv_q[VW-1:0];
          end else begin
            n_e.valid = 1'b1;
            n_e.key   = c_e.key;
            n_e.value = c_e.value;
            out_kv_d  = kv_q;
            dir       = sel_r;
            res       = R_NEXT;
          end
        end
        default: ;
      endcase
    end

    if (res == R_NEXT) end_pos_d = LEVEL'({pos_q, dir});

    node_d = node_q;
    if (wr) node_d[t_idx] = n_e;

    busy_d = up.start;
    op_d   = up.start ? up.op    : op_q;
    pos_d  = up.start ? up.pos   : pos_q;
    kv_d   = up.start ? up.in_kv : kv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      op_q      <= '0;
      pos_q     <= '0;
      kv_q      <= '0;
      out_kv_q  <= '0;
      end_pos_q <= '0;
      for (int i = 0; i < NN; i++) node_q[i] <= '{valid: 1'b0, key: '0, value: '0, cap: CAP_RST};
    end else begin
      busy_q    <= busy_d;
      op_q      <= op_d;
      pos_q     <= pos_d;
      kv_q      <= kv_d;
      out_kv_q  <= out_kv_d;
      end_pos_q <= end_pos_d;
      node_q    <= node_d;
    end
  end

  // Parent reads come from node_d so a same-cycle write is visible (write-first).
  always_comb begin
    pl_idx = PW'({par_addr, 1'b0});
    pr_idx = PW'({par_addr, 1'b1});
    par_l  = node_d[pl_idx];
    par_r  = (NN > 1) ? node_d[pr_idx] : '0;
  end

  assign child_addr = busy_q ? pos_q : up.pos;
  assign up.done    = up.start ? R_BUSY : res;
  assign up.out_kv  = out_kv_d;
  assign up.end_pos = end_pos_d;
  assign head_kv    = {node_q[0].key, node_q[0].value};
  assign full       = (node_q[0].cap == '0);
  assign empty      = !node_q[0].valid;
endmodule

// File: tb/tb_pheap_level_stage.sv
// Directed bench: a LEVEL=2 stage walked through ENQ/DEQ/ENQ_DEQ/FREE steps, plus a LEVEL=1 stage for reset values.
module tb_pheap_level_stage;
  localparam int EW = 20;
  localparam logic [1:0] D_DONE = 2'd0, D_BUSY = 2'd1, D_NEXT = 2'd2;
  localparam logic [1:0] OP_FREE = 2'd0, OP_ENQ = 2'd1, OP_DEQ = 2'd2, OP_ED = 2'd3;
  localparam logic [EW-1:0] M_ALL = 20'hFFFFF, M_VCAP = 20'h80007;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pheap_level_stage_if #(.LEVEL(2), .KW(8), .VW(8)) s2 ();
  pheap_level_stage_if #(.LEVEL(1), .KW(8), .VW(8)) s1 ();

  logic [0:0]    ca2, ca1;
  logic [EW-1:0] cl2 = '0, cr2 = '0, pl2, pr2, pl1, pr1;
  logic [EW-1:0] cz1 = '0;
  logic [0:0]    pa2 = '0, pa1 = '0;
  logic [15:0]   hk2, hk1;
  logic          f2, e2, f1, e1;

  pheap_level_stage #(.LEVEL(2), .LEVELS(3), .KW(8), .VW(8)) dut2 (
    .clk(clk), .rst(rst), .up(s2), .child_addr(ca2), .child_l(cl2), .child_r(cr2),
    .par_addr(pa2), .par_l(pl2), .par_r(pr2), .head_kv(hk2), .full(f2), .empty(e2));

  pheap_level_stage #(.LEVEL(1), .LEVELS(3), .KW(8), .VW(8)) dut1 (
    .clk(clk), .rst(rst), .up(s1), .child_addr(ca1), .child_l(cz1), .child_r(cz1),
    .par_addr(pa1), .par_l(pl1), .par_r(pr1), .head_kv(hk1), .full(f1), .empty(e1));

  function automatic logic [EW-1:0] mk(input logic v, input logic [7:0] k, input logic [7:0] val, input logic [2:0] cap);
    return {v, k, val, cap};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] op, input logic p, input logic [15:0] kv,
                      input logic [EW-1:0] l, input logic [EW-1:0] r, input logic [1:0] exp_done,
                      input logic [15:0] exp_kv, input logic [1:0] exp_ep,
                      input logic [EW-1:0] exp_node, input logic [EW-1:0] mask);
    @(negedge clk);
    s2.start = 1'b1; s2.op = op; s2.pos = p; s2.in_kv = kv; cl2 = l; cr2 = r;
    #1;
    chk({tag, "_busy"}, 64'(s2.done), 64'(D_BUSY));
    chk({tag, "_caddr"}, 64'(ca2), 64'(p));
    @(negedge clk);
    s2.start = 1'b0;
    #1;
    chk({tag, "_done"}, 64'(s2.done), 64'(exp_done));
    if (exp_done == D_NEXT) begin
      chk({tag, "_outkv"}, 64'(s2.out_kv), 64'(exp_kv));
      chk({tag, "_endpos"}, 64'(s2.end_pos), 64'(exp_ep));
    end
    chk({tag, "_bypass"}, 64'((p ? pr2 : pl2) & mask), 64'(exp_node & mask));
    @(posedge clk);
    #1;
    chk({tag, "_node"}, 64'((p ? pr2 : pl2) & mask), 64'(exp_node & mask));
    chk({tag, "_idle"}, 64'(s2.done), 64'(D_DONE));
  endtask

  initial begin
    s2.start = 1'b0; s2.op = '0; s2.pos = '0; s2.in_kv = '0;
    s1.start = 1'b0; s1.op = '0; s1.pos = '0; s1.in_kv = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("l1_empty", 64'(e1), 64'(1'b1));
    chk("l1_full", 64'(f1), 64'(1'b0));
    chk("l1_node0", 64'(pl1), 64'(mk(1'b0, 8'h0, 8'h0, 3'd7)));
    chk("l1_done", 64'(s1.done), 64'(D_DONE));
    chk("l2_rst_n0", 64'(pl2), 64'(mk(1'b0, 8'h0, 8'h0, 3'd3)));
    chk("l2_rst_n1", 64'(pr2), 64'(mk(1'b0, 8'h0, 8'h0, 3'd3)));
    chk("l2_rst_done", 64'(s2.done), 64'(D_DONE));
    chk("l2_rst_outkv", 64'(s2.out_kv), 64'(16'h0));
    chk("l2_rst_endpos", 64'(s2.end_pos), 64'(2'd0));
    chk("l2_rst_empty", 64'(e2), 64'(1'b1));

    step("enq_empty", OP_ENQ, 1'b1, 16'h050A, '0, '0, D_DONE, 16'h0, 2'd0,
         mk(1'b1, 8'h05, 8'h0A, 3'd2), M_ALL);
    step("enq_push", OP_ENQ, 1'b1, 16'h030B, mk(1'b1, 8'h09, 8'h00, 3'd0), mk(1'b0, 8'h00, 8'h00, 3'd1),
         D_NEXT, 16'h050A, 2'd3, mk(1'b1, 8'h03, 8'h0B, 3'd1), M_ALL);
    step("deq_r", OP_DEQ, 1'b1, 16'h0000, mk(1'b1, 8'h07, 8'h77, 3'd0), mk(1'b1, 8'h04, 8'h44, 3'd0),
         D_NEXT, 16'h0444, 2'd3, mk(1'b1, 8'h04, 8'h44, 3'd2), M_ALL);
    step("deq_leaf", OP_DEQ, 1'b1, 16'h0000, '0, '0, D_DONE, 16'h0, 2'd0,
         mk(1'b0, 8'h00, 8'h00, 3'd3), M_VCAP);
    step("ed_keep", OP_ED, 1'b1, 16'h0222, mk(1'b1, 8'h07, 8'h77, 3'd0), mk(1'b1, 8'h04, 8'h44, 3'd0),
         D_DONE, 16'h0, 2'd0, mk(1'b1, 8'h02, 8'h22, 3'd3), M_ALL);
    step("ed_sink", OP_ED, 1'b1, 16'h0888, mk(1'b1, 8'h07, 8'h77, 3'd0), mk(1'b1, 8'h04, 8'h44, 3'd0),
         D_NEXT, 16'h0888, 2'd3, mk(1'b1, 8'h04, 8'h44, 3'd3), M_ALL);
    step("enq_n0", OP_ENQ, 1'b0, 16'h0601, mk(1'b1, 8'h01, 8'h00, 3'd2), mk(1'b1, 8'h01, 8'h00, 3'd2),
         D_DONE, 16'h0, 2'd0, mk(1'b1, 8'h06, 8'h01, 3'd2), M_ALL);
    step("enq_tie", OP_ENQ, 1'b0, 16'h0602, mk(1'b1, 8'h01, 8'h00, 3'd1), mk(1'b1, 8'h01, 8'h00, 3'd1),
         D_NEXT, 16'h0602, 2'd0, mk(1'b1, 8'h06, 8'h01, 3'd1), M_ALL);
    step("enq_full", OP_ENQ, 1'b0, 16'h0403, mk(1'b1, 8'h01, 8'h00, 3'd0), mk(1'b1, 8'h02, 8'h00, 3'd1),
         D_NEXT, 16'h0601, 2'd1, mk(1'b1, 8'h04, 8'h03, 3'd0), M_ALL);
    chk("full_set", 64'(f2), 64'(1'b1));
    chk("empty_clr", 64'(e2), 64'(1'b0));
    chk("head_kv", 64'(hk2), 64'(16'h0403));
    step("free", OP_FREE, 1'b1, 16'hFFFF, '0, '0, D_DONE, 16'h0, 2'd0,
         mk(1'b1, 8'h04, 8'h44, 3'd3), M_ALL);
    chk("hold_outkv", 64'(s2.out_kv), 64'(16'h0601));
    chk("hold_endpos", 64'(s2.end_pos), 64'(2'd1));

    // Reset lands in the resolve cycle of an ENQ; nothing from that step may survive.
    @(negedge clk);
    s2.start = 1'b1; s2.op = OP_ENQ; s2.pos = 1'b1; s2.in_kv = 16'h0101; cl2 = '0; cr2 = '0;
    @(negedge clk);
    s2.start = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_done", 64'(s2.done), 64'(D_DONE));
    chk("abort_n1", 64'(pr2), 64'(mk(1'b0, 8'h00, 8'h00, 3'd3)));
    chk("abort_outkv", 64'(s2.out_kv), 64'(16'h0));
    chk("abort_endpos", 64'(s2.end_pos), 64'(2'd0));
    chk("abort_empty", 64'(e2), 64'(1'b1));
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
